group_fwd_buffer: RTL and testbench
===================================

# group_fwd_buffer

Parametrised group-synchronized forwarding buffer between the SFTM producer and the DPM consumer in the VCNPU pipeline. It generalises the fixed group FIFO with several changes: configurable group size and depth, variable-length groups closed by `wr_last`, a built-in credit count, a per-group last-word flag on the read side, and optional abort/rollback of a partially written group. Data written into a group becomes visible to the reader only after the whole group is committed.

## Interface
- `DATA_W`, 16: word width.
- `GROUP_WORDS`, 16: maximum words per group; must be ≥2.
- `DEPTH_GROUPS`, 4: number of group slots; must be a power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH_GROUPS+1)`: width of the count outputs (derived).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_valid`  in  1  write beat offered.
- `wr_data`  in  DATA_W  write word.
- `wr_last`  in  1  closes the current group early on this beat (a short group).
- `wr_abort`  in  1  discards the partial group (effective only with `GFB_ABORT_EN`).
- `wr_ready`  out  1  buffer accepts a write beat.
- `rd_valid`  out  1  a committed word is available.
- `rd_data`  out  DATA_W  read word.
- `rd_last`  out  1  `rd_data` is the final word of its group.
- `rd_ready`  in  1  consumer takes the word.
- `credits`  out  CNT_W  free group slots, equal to DEPTH_GROUPS − occupied.
- `groups_ready`  out  CNT_W  committed groups not yet fully read (`occupied`).
- `err_overflow`  out  1  sticky: `wr_valid` was seen while `wr_ready` = 0.

## Operation
- Storage: DEPTH_GROUPS × GROUP_WORDS words, plus a per-slot length register.
- Pointers and counters:
  - `wr_ptr` / `rd_ptr`: slot indices; they wrap modulo DEPTH_GROUPS.
  - `wr_idx` / `rd_idx`: word indices within the current slot.
  - `occupied`: 0..DEPTH_GROUPS.
- `wr_ready` = (`occupied` < DEPTH_GROUPS). The slot at `wr_ptr` is always free while `wr_ready` = 1.
- Write beat (`wr_valid & wr_ready`):
  - Store the word at [`wr_ptr`][`wr_idx`].
  - Commit when `wr_last` = 1 or `wr_idx` = GROUP_WORDS−1.
  - On commit: record length `wr_idx`+1, advance `wr_ptr`, clear `wr_idx`, increment `occupied`.
  - Otherwise increment `wr_idx`.
- Read side:
  - `rd_valid` = (`occupied` > 0).
  - `rd_data` = mem[`rd_ptr`][`rd_idx`].
  - `rd_last` = `rd_valid` & (`rd_idx` = len[`rd_ptr`]−1).
- Read beat (`rd_valid & rd_ready`):
  - If `rd_last`: advance `rd_ptr`, clear `rd_idx`, decrement `occupied` (group release).
  - Otherwise increment `rd_idx`.
- Simultaneous commit and release in one cycle: `occupied` is unchanged and both pointers advance.
- Partial group: nothing in it is visible on the read side. A partial group's words count in neither `credits` nor `groups_ready`.
- `err_overflow` is set by `wr_valid & !wr_ready`. The offending beat is dropped with no state change. The flag is cleared only by reset.
- `wr_last` on a beat that is not accepted has no effect.

## Timing
- Reset (`rst_n` = 0 at a rising edge) clears all pointers, indices, `occupied` and `err_overflow`. During reset:
  - `wr_ready` = 0.
  - `rd_valid` = 0, `rd_last` = 0, `rd_data` = 0.
  - `credits` = DEPTH_GROUPS.
  - `groups_ready` = 0.
  - `err_overflow` = 0.
- After reset, `wr_ready` = 1 in the first cycle with `rst_n` = 1.
- Reset mid-operation discards all groups, including committed and unread ones, with no partial output.
- Commit-to-visibility latency: `rd_valid` rises the cycle after the committing write edge.
- Release-to-credit latency: `wr_ready` and `credits` update the cycle after the releasing read edge.
- Reads are first-word-fall-through: the read side sustains one word per cycle, and a group's last word is followed directly by the next group's first word.
- Writes sustain one word per cycle while `credits` > 0.
- Throughput with full buffer: the writer stalls exactly until the first release, then resumes the next cycle.

## Configuration
- `GFB_ABORT_EN` defined:
  - `wr_abort` = 1 in a cycle clears `wr_idx` to 0 and leaves `wr_ptr` unchanged. Any write beat in that same cycle is dropped, even with `wr_last`.
  - The read side and `occupied` are unaffected.
  - Abort with `wr_idx` = 0 is a no-op.
- `GFB_ABORT_EN` undefined: `wr_abort` is ignored (port retained, unused).

## Test plan
Bench configuration: GROUP_WORDS=4, DEPTH_GROUPS=2.
- Write 4 words 0x11..0x14; hold `rd_ready` = 0. `rd_valid` stays 0 through the 4th write edge and goes to 1 one cycle later. `credits` 2→1, `groups_ready` 0→1. Then read 0x11..0x14 with `rd_last` only on 0x14; `credits` returns to 2.
- Short group: write 0xA0, 0xA1 with `wr_last` on 0xA1. Read returns 2 words, `rd_last` on 0xA1. Then a full group 0xB0..0xB3 reads back intact.
- Fill 2 groups with `rd_ready` = 0: `wr_ready` = 0 and `credits` = 0. A 9th `wr_valid` sets `err_overflow` = 1 and that data is never read. Reading one group restores `wr_ready` on the next cycle.
- Steady streaming with `wr_valid` = `rd_ready` = 1 for 40 cycles: no stall after the first group commits, commit and release coincide, and `groups_ready` holds at 1 while the output order matches the input order.
- With `GFB_ABORT_EN`: write 0xC0, 0xC1, then abort, then write 0xD0..0xD3. Only 0xD0..0xD3 is read. Without the macro, 0xC0, 0xC1, 0xD0, 0xD1 form the first group.
- Assert reset with one committed group and one partial group: after reset, `groups_ready` = 0, `credits` = 2, `err_overflow` = 0, and the next written group reads back correctly.

Source files
------------

// File: rtl/group_fwd_buffer.sv
// -----------------------------------------------------------------------------
// group_fwd_buffer
//
// Group-synchronized forwarding buffer between the SFTM producer and the DPM
// consumer. Words are written into group slots. A group becomes visible to the
// reader only after it is committed, either by wr_last or by filling the slot.
// The read side is first-word-fall-through and marks the final word of each
// group with rd_last.
//
// Optional feature macro: GFB_ABORT_EN
//   defined   : wr_abort discards the partially written group (wr_idx -> 0)
//   undefined : wr_abort is ignored (port kept for a stable interface)
//
// Parameters
//   DATA_W       word width
//   GROUP_WORDS  maximum words per group (>= 2)
//   DEPTH_GROUPS number of group slots (power of two, >= 2)
//   CNT_W        width of credits / groups_ready (derived)
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   wr_valid     write beat offered
//   wr_data      write word
//   wr_last      closes the current group on this beat
//   wr_abort     discard the partial group (GFB_ABORT_EN only)
//   wr_ready     buffer accepts a write beat
//   rd_valid     a committed word is available
//   rd_data      read word (0 while rd_valid = 0)
//   rd_last      rd_data is the final word of its group
//   rd_ready     consumer takes the word
//   credits      free group slots (DEPTH_GROUPS - occupied)
//   groups_ready committed groups not yet fully read
//   err_overflow sticky: wr_valid seen while wr_ready = 0
// -----------------------------------------------------------------------------
module group_fwd_buffer #(
  parameter int DATA_W       = 16,
  parameter int GROUP_WORDS  = 16,
  parameter int DEPTH_GROUPS = 4,
  parameter int CNT_W        = $clog2(DEPTH_GROUPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              wr_abort,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  credits,
  output logic [CNT_W-1:0]  groups_ready,
  output logic              err_overflow
);

  localparam int PTR_W = $clog2(DEPTH_GROUPS);
  localparam int IDX_W = $clog2(GROUP_WORDS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_GROUPS);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(GROUP_WORDS - 1);

  // Word storage and per-slot index of the last valid word (length - 1).
  logic [DATA_W-1:0] r_mem      [DEPTH_GROUPS][GROUP_WORDS];
  logic [IDX_W-1:0]  r_len_last [DEPTH_GROUPS];

  // Control state
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [CNT_W-1:0] r_occ;
  logic             r_err;

  logic w_abort;
  logic w_wr_ready;
  logic w_rd_valid;
  logic w_wr_fire;
  logic w_commit;
  logic w_rd_last;
  logic w_release;
  logic w_rd_adv;

`ifdef GFB_ABORT_EN
  assign w_abort = wr_abort;
`else
  logic w_unused_abort;
  assign w_unused_abort = wr_abort;
  assign w_abort        = 1'b0;
`endif

  // Outputs are forced to their reset values while rst_n is low, so the
  // handshake is closed during reset even before the first reset edge.
  assign w_wr_ready = rst_n & (r_occ < DEPTH_C);
  assign w_rd_valid = rst_n & (r_occ != '0);

  // An abort cycle drops any write beat offered alongside it, wr_last included.
  assign w_wr_fire = wr_valid & w_wr_ready & ~w_abort;
  assign w_commit  = w_wr_fire & (wr_last | (r_wr_idx == IDX_MAX));

  assign w_rd_last = w_rd_valid & (r_rd_idx == r_len_last[r_rd_ptr]);
  assign w_release = w_rd_valid & rd_ready & w_rd_last;
  assign w_rd_adv  = w_rd_valid & rd_ready & ~w_rd_last;

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_occ    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_abort) begin
        r_wr_idx <= '0;
      end else if (w_commit) begin
        r_wr_idx <= '0;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end else if (w_wr_fire) begin
        r_wr_idx <= r_wr_idx + IDX_W'(1);
      end

      if (w_release) begin
        r_rd_idx <= '0;
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else if (w_rd_adv) begin
        r_rd_idx <= r_rd_idx + IDX_W'(1);
      end

      // Commit and release in the same cycle leave the count unchanged.
      case ({w_commit, w_release})
        2'b10:   r_occ <= r_occ + CNT_W'(1);
        2'b01:   r_occ <= r_occ - CNT_W'(1);
        default: r_occ <= r_occ;
      endcase

      if (wr_valid & ~w_wr_ready) begin
        r_err <= 1'b1;
      end
    end
  end

  // Storage (not reset; contents are only observed once committed)
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr][r_wr_idx] <= wr_data;
    end
    if (w_commit) begin
      r_len_last[r_wr_ptr] <= r_wr_idx;
    end
  end

  assign wr_ready     = w_wr_ready;
  assign rd_valid     = w_rd_valid;
  assign rd_data      = w_rd_valid ? r_mem[r_rd_ptr][r_rd_idx] : '0;
  assign rd_last      = w_rd_last;
  assign groups_ready = rst_n ? r_occ : '0;
  assign credits      = DEPTH_C - groups_ready;
  assign err_overflow = rst_n & r_err;

endmodule

// File: tb/tb_group_fwd_buffer.sv
// -----------------------------------------------------------------------------
// tb_group_fwd_buffer
//
// Self-checking bench for group_fwd_buffer with GROUP_WORDS=4, DEPTH_GROUPS=2.
// A table of per-cycle {inputs, expected outputs} covers the basic group,
// short group and full-buffer/overflow cases; hand-written sequences cover
// streaming, abort (GFB_ABORT_EN dependent) and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_group_fwd_buffer;

  localparam int DATA_W       = 16;
  localparam int GROUP_WORDS  = 4;
  localparam int DEPTH_GROUPS = 2;
  localparam int CNT_W        = 2;

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_abort;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_ready;
  logic [CNT_W-1:0]  credits;
  logic [CNT_W-1:0]  groups_ready;
  logic              err_overflow;

  group_fwd_buffer #(
    .DATA_W      (DATA_W),
    .GROUP_WORDS (GROUP_WORDS),
    .DEPTH_GROUPS(DEPTH_GROUPS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_abort    (wr_abort),
    .wr_ready    (wr_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rd_ready    (rd_ready),
    .credits     (credits),
    .groups_ready(groups_ready),
    .err_overflow(err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wv;
    logic [15:0] wd;
    logic        wl;
    logic        rr;
    logic        wrdy;
    logic        rv;
    logic [15:0] rdd;
    logic        rl;
    logic [1:0]  cr;
    logic [1:0]  gr;
    logic        er;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   sq[$];
  int   rc;
  int   exp_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(logic wv, logic [15:0] wd, logic wl, logic rr,
                              logic wrdy, logic rv, logic [15:0] rdd, logic rl,
                              logic [1:0] cr, logic [1:0] gr, logic er);
    vec_t v;
    v.wv = wv; v.wd = wd; v.wl = wl; v.rr = rr;
    v.wrdy = wrdy; v.rv = rv; v.rdd = rdd; v.rl = rl;
    v.cr = cr; v.gr = gr; v.er = er;
    vecs.push_back(v);
  endfunction

  task automatic wr_beat(input logic [15:0] d, input logic l);
    wr_valid = 1'b1; wr_data = d; wr_last = l; rd_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("wr_ready@%0h", d), 32'(wr_ready), 32'(1));
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic rd_word(input logic [15:0] d, input logic l);
    rd_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("rd_valid@%0h", d), 32'(rd_valid), 32'(1));
    chk($sformatf("rd_data@%0h", d), 32'(rd_data), 32'(d));
    chk($sformatf("rd_last@%0h", d), 32'(rd_last), 32'(l));
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic chk_empty(input string nm);
    @(negedge clk);
    chk({nm, "_rv"}, 32'(rd_valid), 32'(0));
    chk({nm, "_gr"}, 32'(groups_ready), 32'(0));
    chk({nm, "_cr"}, 32'(credits), 32'(2));
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    wr_abort = 1'b0; rd_ready = 1'b0;

    // Test 1: full group 0x11..0x14, visibility after 4th write edge
    for (int i = 0; i < 4; i++) add(1, 16'(16'h11 + i), 0, 0, 1, 0, 16'h0, 0, 2, 0, 0);
    add(0, 16'h0, 0, 0, 1, 1, 16'h11, 0, 1, 1, 0);
    add(0, 16'h0, 0, 1, 1, 1, 16'h11, 0, 1, 1, 0);
    add(0, 16'h0, 0, 1, 1, 1, 16'h12, 0, 1, 1, 0);
    add(0, 16'h0, 0, 1, 1, 1, 16'h13, 0, 1, 1, 0);
    add(0, 16'h0, 0, 1, 1, 1, 16'h14, 1, 1, 1, 0);
    add(0, 16'h0, 0, 0, 1, 0, 16'h0,  0, 2, 0, 0);
    // Test 2: short group then a full group
    add(1, 16'hA0, 0, 0, 1, 0, 16'h0, 0, 2, 0, 0);
    add(1, 16'hA1, 1, 0, 1, 0, 16'h0, 0, 2, 0, 0);
    add(0, 16'h0, 0, 1, 1, 1, 16'hA0, 0, 1, 1, 0);
    add(0, 16'h0, 0, 1, 1, 1, 16'hA1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 16'(16'hB0 + i), 0, 0, 1, 0, 16'h0, 0, 2, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 16'h0, 0, 1, 1, 1, 16'(16'hB0 + i), logic'(i == 3), 1, 1, 0);
    add(0, 16'h0, 0, 0, 1, 0, 16'h0, 0, 2, 0, 0);
    // Test 3: fill both slots, overflow beat, release restores wr_ready
    for (int i = 0; i < 4; i++) add(1, 16'(16'h30 + i), 0, 0, 1, 0, 16'h0, 0, 2, 0, 0);
    for (int i = 4; i < 8; i++) add(1, 16'(16'h30 + i), 0, 0, 1, 1, 16'h30, 0, 1, 1, 0);
    add(1, 16'h99, 0, 0, 0, 1, 16'h30, 0, 0, 2, 0);
    add(0, 16'h0,  0, 0, 0, 1, 16'h30, 0, 0, 2, 1);
    for (int i = 0; i < 4; i++) add(0, 16'h0, 0, 1, 0, 1, 16'(16'h30 + i), logic'(i == 3), 0, 2, 1);
    add(0, 16'h0, 0, 0, 1, 1, 16'h34, 0, 1, 1, 1);
    for (int i = 4; i < 8; i++) add(0, 16'h0, 0, 1, 1, 1, 16'(16'h30 + i), logic'(i == 7), 1, 1, 1);
    add(0, 16'h0, 0, 0, 1, 0, 16'h0, 0, 2, 0, 1);

    // Reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_last",  32'(rd_last),  32'(0));
    chk("rst_rd_data",  32'(rd_data),  32'(0));
    chk("rst_credits",  32'(credits),  32'(2));
    chk("rst_groups",   32'(groups_ready), 32'(0));
    chk("rst_err",      32'(err_overflow), 32'(0));
    tick();
    rst_n = 1'b1;

    // Table-driven part
    for (int i = 0; i < vecs.size(); i++) begin
      wr_valid = vecs[i].wv; wr_data = vecs[i].wd; wr_last = vecs[i].wl;
      rd_ready = vecs[i].rr; wr_abort = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d{wrdy,rv,data,rl,cr,gr,err}", i),
          32'({wr_ready, rd_valid, rd_data, rd_last, credits, groups_ready, err_overflow}),
          32'({vecs[i].wrdy, vecs[i].rv, vecs[i].rdd, vecs[i].rl, vecs[i].cr, vecs[i].gr, vecs[i].er}));
      tick();
    end
    wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;

    // Steady streaming: write and read every cycle
    rc = 0;
    for (int i = 0; i < 44; i++) begin
      wr_valid = (i < 40); wr_data = 16'(16'h100 + i); wr_last = 1'b0; rd_ready = 1'b1;
      @(negedge clk);
      if (i < 40) begin
        chk($sformatf("stream_stall%0d", i), 32'(wr_ready), 32'(1));
        chk($sformatf("stream_rv%0d", i), 32'(rd_valid), 32'(i >= 4));
        chk($sformatf("stream_gr%0d", i), 32'(groups_ready), 32'(i >= 4));
      end
      if (rd_valid) begin
        if (sq.size() == 0) begin
          chk($sformatf("stream_unexpected_read%0d", i), 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          exp_w = sq.pop_front();
          chk($sformatf("stream_data%0d", rc), 32'(rd_data), 32'(exp_w));
          chk($sformatf("stream_last%0d", rc), 32'(rd_last), 32'((rc % 4) == 3));
          rc++;
        end
      end
      if (wr_valid && wr_ready) sq.push_back(int'(wr_data));
      tick();
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("stream_read_count", 32'(rc), 32'(40));
    chk_empty("stream_end");
    tick();

    // Abort of a partial group
    wr_beat(16'hC0, 1'b0);
    wr_beat(16'hC1, 1'b0);
    wr_abort = 1'b1;
    @(negedge clk);
    chk("abort_rv", 32'(rd_valid), 32'(0));
    tick();
    wr_abort = 1'b0;
    for (int i = 0; i < 4; i++) wr_beat(16'(16'hD0 + i), 1'b0);
`ifdef GFB_ABORT_EN
    for (int i = 0; i < 4; i++) rd_word(16'(16'hD0 + i), logic'(i == 3));
`else
    rd_word(16'hC0, 1'b0);
    rd_word(16'hC1, 1'b0);
    rd_word(16'hD0, 1'b0);
    rd_word(16'hD1, 1'b1);
    chk_empty("noabort_mid");
    tick();
    wr_beat(16'hD4, 1'b1);
    rd_word(16'hD2, 1'b0);
    rd_word(16'hD3, 1'b0);
    rd_word(16'hD4, 1'b1);
`endif
    chk_empty("abort_end");
    tick();

    // Reset with one committed and one partial group
    for (int i = 0; i < 4; i++) wr_beat(16'(16'hF0 + i), 1'b0);
    wr_beat(16'hF4, 1'b0);
    wr_beat(16'hF5, 1'b0);
    @(negedge clk);
    chk("prerst_gr",  32'(groups_ready), 32'(1));
    chk("prerst_cr",  32'(credits),      32'(1));
    chk("prerst_err", 32'(err_overflow), 32'(1));
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs",
        32'({wr_ready, rd_valid, rd_data, rd_last, credits, groups_ready, err_overflow}),
        32'({1'b0, 1'b0, 16'h0, 1'b0, 2'd2, 2'd0, 1'b0}));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_wr_ready", 32'(wr_ready), 32'(1));
    chk("postrst_err",      32'(err_overflow), 32'(0));
    chk_empty("postrst");
    tick();
    for (int i = 0; i < 4; i++) wr_beat(16'(16'h50 + i), 1'b0);
    for (int i = 0; i < 4; i++) rd_word(16'(16'h50 + i), logic'(i == 3));
    chk_empty("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
